// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order, digit patterns and BCD codes.
// Used by both the BCD->7-seg decoder and the scan reader.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    // Segment bit positions inside a seg_t; active-high, a is the MSB.
    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;

    localparam seg_t SEG_0 = 7'b1111110;
    localparam seg_t SEG_1 = 7'b0110000;
    localparam seg_t SEG_2 = 7'b1101101;
    localparam seg_t SEG_3 = 7'b1111001;
    localparam seg_t SEG_4 = 7'b0110011;
    localparam seg_t SEG_5 = 7'b1011011;
    localparam seg_t SEG_6 = 7'b1011111;
    localparam seg_t SEG_7 = 7'b1110000;
    localparam seg_t SEG_8 = 7'b1111111;
    localparam seg_t SEG_9 = 7'b1111011;

    localparam bcd_t BCD_ILLEGAL = 4'hF;

    // Digit selects are at most 8 wide; callers zero-extend into this.
    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/seg7_bcd_encoder.sv
// Combinational 7-segment pattern to BCD encoder; unknown patterns map to BCD_ILLEGAL.
module seg7_bcd_encoder
    import seg7_pkg::*;
(
    input  seg_t seg,
    output bcd_t code,
    output logic legal
);

    always_comb begin
        case (seg)
            SEG_0:   code = 4'd0;
            SEG_1:   code = 4'd1;
            SEG_2:   code = 4'd2;
            SEG_3:   code = 4'd3;
            SEG_4:   code = 4'd4;
            SEG_5:   code = 4'd5;
            SEG_6:   code = 4'd6;
            SEG_7:   code = 4'd7;
            SEG_8:   code = 4'd8;
            SEG_9:   code = 4'd9;
            default: code = BCD_ILLEGAL;
        endcase
    end

    assign legal = (code != BCD_ILLEGAL);

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed 7-segment bus, debounces each digit and reports BCD plus an all-equal flag.
// Optional SEG7_INPUT_SYNC_EN adds a two-flop synchronizer on the sampled inputs.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int STABLE_COUNT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic                    all_match,
    output logic                    sel_err
);

    localparam int             CW      = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_COUNT);

    logic                  s_valid;
    seg_t                  s_seg;
    logic [NUM_DIGITS-1:0] s_sel;

`ifdef SEG7_INPUT_SYNC_EN
    logic [1:0]            valid_sync;
    seg_t                  seg_sync [2];
    logic [NUM_DIGITS-1:0] sel_sync [2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sync  <= '0;
            seg_sync[0] <= '0;
            seg_sync[1] <= '0;
            sel_sync[0] <= '0;
            sel_sync[1] <= '0;
        end else begin
            valid_sync  <= {valid_sync[0], sample_valid};
            seg_sync[0] <= seg_in;
            seg_sync[1] <= seg_sync[0];
            sel_sync[0] <= dig_sel;
            sel_sync[1] <= sel_sync[0];
        end
    end

    assign s_valid = valid_sync[1];
    assign s_seg   = seg_sync[1];
    assign s_sel   = sel_sync[1];
`else
    assign s_valid = sample_valid;
    assign s_seg   = seg_in;
    assign s_sel   = dig_sel;
`endif

    logic sel_onehot;
    logic accept;
    bcd_t code;
    logic legal;

    assign sel_onehot = is_onehot8(8'(s_sel));
    assign accept     = s_valid && sel_onehot;

    seg7_bcd_encoder u_encoder (
        .seg   (s_seg),
        .code  (code),
        .legal (legal)
    );

    logic [NUM_DIGITS-1:0]   commit;
    logic [NUM_DIGITS-1:0]   valid_nxt;
    logic [4*NUM_DIGITS-1:0] bcd_nxt;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_t          cand_q, cand_d;
        bcd_t          bcd_q,  bcd_d;
        logic [CW-1:0] cnt_q,  cnt_d;
        logic          valid_q, valid_d;
        logic          commit_d;

        // NOTE: every combinational output gets a default first so no latch is inferred.
        always_comb begin
            cand_d   = cand_q;
            cnt_d    = cnt_q;
            bcd_d    = bcd_q;
            valid_d  = valid_q;
            commit_d = 1'b0;
            if (accept && s_sel[i]) begin
                if (code == cand_q) begin
                    if (cnt_q != CNT_MAX)
                        cnt_d = cnt_q + 1'b1;
                end else begin
                    cand_d = code;
                    cnt_d  = CW'(1);
                end
                // Re-committing the value already shown is suppressed so update stays quiet.
                if (cnt_d == CNT_MAX && (code != bcd_q || valid_q != legal)) begin
                    bcd_d    = code;
                    valid_d  = legal;
                    commit_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cand_q  <= BCD_ILLEGAL;
                cnt_q   <= '0;
                bcd_q   <= BCD_ILLEGAL;
                valid_q <= 1'b0;
            end else begin
                cand_q  <= cand_d;
                cnt_q   <= cnt_d;
                bcd_q   <= bcd_d;
                valid_q <= valid_d;
            end
        end

        assign bcd_out[4*i +: 4] = bcd_q;
        assign digit_valid[i]    = valid_q;
        assign commit[i]         = commit_d;
        assign bcd_nxt[4*i +: 4] = bcd_d;
        assign valid_nxt[i]      = valid_d;
    end

    // Match is judged on the values being committed this edge, so it lines up with bcd_out.
    logic match_d;
    always_comb begin
        match_d = &valid_nxt;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (bcd_nxt[4*i +: 4] != bcd_nxt[3:0])
                match_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update    <= 1'b0;
            all_match <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            update    <= |commit;
            all_match <= match_d;
            sel_err   <= s_valid && !sel_onehot;
        end
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
Reader side of the seven-segment digit path. Samples a multiplexed 7-segment bus (segment lines plus one-hot digit select) and converts each digit's pattern back to BCD. Requires a per-digit stability check before a value is committed. Sits on the slot-machine display path as a self-check/readback of the reel digits and flags when all reels show the same digit.

Parameters:
NUM_DIGITS, 3, number of multiplexed digits (1..8)
STABLE_COUNT, 2, consecutive identical samples per digit required to commit (min 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sample_valid  input  1  seg_in/dig_sel are valid this cycle
seg_in  input  7  segment pattern, bit6=a … bit0=g, active-high
dig_sel  input  NUM_DIGITS  one-hot digit select; bit i = digit i
bcd_out  output  4*NUM_DIGITS  committed BCD; digit i at [4i+3:4i]
digit_valid  output  NUM_DIGITS  committed digit i holds a legal pattern
update  output  1  one-cycle pulse: some committed digit changed value or validity
all_match  output  1  all digits valid and equal
sel_err  output  1  one-cycle pulse: sample_valid with dig_sel not one-hot

Behaviour:
- Pattern map: 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9. Any other pattern, including all-zero blank, → code 4'hF (illegal).
- Acceptance: a sample is accepted when sample_valid=1 and dig_sel is exactly one-hot.
  - sample_valid=1 with zero or more than one bit set → sample discarded, no state change, sel_err=1 next cycle.
  - sample_valid=0 → nothing happens.
- Per-digit state: cand[3:0], cnt (saturating at STABLE_COUNT), committed bcd[3:0], valid.
- Accepted sample for digit i with code c:
  - c==cand_i → cnt_i increments, saturating at STABLE_COUNT.
  - c!=cand_i → cand_i=c, cnt_i=1.
  - Commit when the new cnt_i equals STABLE_COUNT and (c!=bcd_i or valid_i!=(c!=F)): bcd_i=c, valid_i=(c!=4'hF), update=1.
  - STABLE_COUNT=1 commits on the first accepted sample.
  - Re-committing an identical value does not pulse update.
- Digits not selected are untouched.
- Latency: outputs, update and all_match change on the clock edge after the accepting edge, i.e. 1 cycle.
- all_match: registered; =1 iff &digit_valid and every bcd_i equal, evaluated on post-commit values. NUM_DIGITS=1 → all_match=digit_valid[0].
- Reset (async assert, any time, mid-stream included): bcd_out all 4'hF, digit_valid=0, cand=4'hF, cnt=0, update=0, all_match=0, sel_err=0. The first accepted sample after release starts a fresh count.
- An illegal pattern that is stable for STABLE_COUNT samples drops digit_valid_i to 0, sets bcd_i to F and clears all_match.

Optional Feature:
- Macro: SEG7_INPUT_SYNC_EN.
- Defined: sample_valid, seg_in and dig_sel pass through a two-flop synchronizer (reset to 0) before acceptance; total latency 3 cycles; sel_err is delayed the same amount.
- Undefined: inputs are used directly; latency 1 cycle.

Decomposition:
- Shared package seg7_pkg: SEG_0..SEG_9 pattern constants (shared with the existing BCD→7-seg decoder), BCD_ILLEGAL=4'hF, segment bit-order definition.
- Sub-module seg7_bcd_encoder: purely combinational, 7-bit pattern→4-bit code plus legal flag. Instantiated once, on the accepted sample.
- Top module holds the per-digit stability registers (generate loop) and the match logic.

Test Plan:
- Reset then STABLE_COUNT=2, NUM_DIGITS=3: digit0 fed 0110000 twice → after 2nd sample bcd_out[3:0]=1, digit_valid=001, update pulses once; a 3rd identical sample gives no update.
- Digits 0,1,2 each fed 1111011 twice → all_match=1 one cycle after the last commit; then digit1 fed 1011011 twice → bcd 5, all_match=0.
- Alternate 1101101 / 1111001 on digit2 each sample → never commits, bcd_out[11:8] stays F, update never pulses.
- sample_valid with dig_sel=011 and with 000 → sel_err pulses, no state change.
- Digit0 committed 7, then 0000000 twice → bcd 4'hF, digit_valid[0]=0, update pulses.
- Assert rst_n low between two matching samples → outputs return to reset values immediately; after release one sample does not commit (cnt restarts). Repeat with SEG7_INPUT_SYNC_EN defined and check commit arrives 3 cycles after the second sample.
